// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the program loader
package imem_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LEN0 = ST_LEN0,
        LEN1 = ST_LEN1,
        DATA = ST_DATA,
        CSUM = ST_CSUM,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_asm.sv
// rtl/imem_loader_word_asm.sv - little-endian byte-to-word assembler for the program loader
module imem_loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        last_lane,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    logic [23:0] shift;

    // The next accepted byte completes the word.
    assign last_lane = (lane == 2'd3);

    // Shift bytes in from the top so byte0 ends up in [7:0]; publish on the fourth byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= 2'd0;
            shift      <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane <= 2'd0;
            end else if (byte_valid) begin
                if (last_lane) begin
                    word       <= {byte_data, shift};
                    word_valid <= 1'b1;
                    lane       <= 2'd0;
                end else begin
                    shift <= {byte_data, shift[23:8]};
                    lane  <= lane + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing the instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int MEM_SIZE       = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int IDX_W  = ADDR_WIDTH + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t     state, state_next;
    logic [7:0]        sum;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [IDX_W-1:0]  idx;
    logic [IDLE_W-1:0] idle_cnt;

    logic        start_frame;
    logic        asm_valid;
    logic        last_lane;
    logic        in_frame;
    logic        last_word;
    logic        timeout_hit;
    logic [15:0] len_rx;

    assign in_frame    = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign len_rx      = {rx_data, len_lo};
    // Index is one bit wider than the address so a full-size image ends without wrapping.
    assign last_word   = ((17'(idx) + 17'd1) == {1'b0, len});
    assign timeout_hit = in_frame && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Status is a pure decode of the state; ERR keeps the CPU held so a partial image never runs.
    assign busy     = in_frame;
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_hold = in_frame || (state == ERR);

    imem_loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_frame),
        .byte_data  (rx_data),
        .byte_valid (asm_valid),
        .last_lane  (last_lane),
        .word       (wdata),
        .word_valid (we)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame parser: next state and per-byte control strobes.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        asm_valid   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (rx_valid && (rx_data == LOADER_MAGIC)) begin
                    state_next  = LEN0;
                    start_frame = 1'b1;
                end
            end
            LEN0: begin
                if (rx_valid) state_next = LEN1;
            end
            LEN1: begin
                if (rx_valid) begin
                    if ({1'b0, len_rx} > 17'(MEM_SIZE)) state_next = ERR;
                    else if (len_rx == 16'd0)          state_next = CSUM;
                    else                               state_next = DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    asm_valid = 1'b1;
                    if (last_lane && last_word) state_next = CSUM;
                end
            end
            CSUM: begin
                if (rx_valid) state_next = (rx_data == sum) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
        if (timeout_hit) state_next = ERR;
    end

    // Length, checksum, word index, write address and inter-byte idle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum      <= 8'd0;
            len_lo   <= 8'd0;
            len      <= 16'd0;
            idx      <= '0;
            idle_cnt <= '0;
            waddr    <= '0;
        end else if (start_frame) begin
            sum      <= 8'd0;
            idx      <= '0;
            idle_cnt <= '0;
        end else begin
            if (!in_frame || rx_valid) idle_cnt <= '0;
            else                       idle_cnt <= idle_cnt + IDLE_W'(1);
            if (rx_valid && ((state == LEN0) || (state == LEN1) || (state == DATA))) begin
                sum <= sum + rx_data;
            end
            if (rx_valid && (state == LEN0)) len_lo <= rx_data;
            if (rx_valid && (state == LEN1)) len <= len_rx;
            if (asm_valid && last_lane) begin
                waddr <= idx[ADDR_WIDTH-1:0];
                idx   <= idx + IDX_W'(1);
            end
        end
    end

endmodule
